btn_step_debouncer: RTL and testbench

//  Upstream stage of up_counter: turns a raw, bouncy push-button into a clean

---
 rtl/btn_step_pkg.sv | 18 +
 rtl/sync_2ff.sv | 23 ++
 rtl/btn_step_debouncer.sv | 122 ++++++++++++
 tb/tb_btn_step_debouncer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/btn_step_pkg.sv
// Shared types and sizing helpers for the push-button step debouncer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package btn_step_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } btn_state_t;

    // Smallest counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous bit; reset clears both stages.
// Latency: 2 clk cycles from d to q.
// Backpressure: none, free-running.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_step_debouncer.sv
// Bouncy push-button to single-cycle step pulse; AUTO_REPEAT_EN adds hold-to-repeat.
// Latency: step fires DEBOUNCE_CYCLES+2 edges after btn_in settles high.
// Backpressure: none; step is a fire-and-forget pulse, never high two cycles running.
module btn_step_debouncer
    import btn_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic step,
    output logic btn_level
);

    localparam int DBW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DBW-1:0] DB_ONE  = DBW'(1);

    btn_state_t     state;
    logic [DBW-1:0] db_cnt;
    logic           btn_s;
    logic           rep_fire;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (btn_s)
    );

`ifdef AUTO_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPW     = cnt_width(REP_MAX);

    logic [RPW-1:0] rep_cnt;
    logic [RPW-1:0] rep_last;
    logic           rep_armed;

    // First repeat waits the long delay, later ones use the shorter period.
    assign rep_last = rep_armed ? RPW'(REPEAT_PERIOD - 1) : RPW'(REPEAT_DELAY - 1);
    assign rep_fire = (state == HELD) && btn_s && (rep_cnt == rep_last);

    always_ff @(posedge clk) begin
        if (rst || (state != HELD) || !btn_s) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
        end else if (rep_fire) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b1;
        end else begin
            rep_cnt <= rep_cnt + RPW'(1);
        end
    end
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            db_cnt    <= '0;
            step      <= 1'b0;
            btn_level <= 1'b0;
        end else begin
            step <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_s) begin
                        state  <= PRESS_CHK;
                        db_cnt <= DB_ONE;
                    end
                end
                PRESS_CHK: begin
                    if (!btn_s) begin
                        state  <= IDLE;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state     <= HELD;
                        db_cnt    <= '0;
                        step      <= 1'b1;
                        btn_level <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + DB_ONE;
                    end
                end
                HELD: begin
                    if (!btn_s) begin
                        state  <= REL_CHK;
                        db_cnt <= DB_ONE;
                    end else if (rep_fire) begin
                        step <= 1'b1;
                    end
                end
                REL_CHK: begin
                    // A short dropout returns to HELD silently; only a full
                    // debounce window of lows counts as a release.
                    if (btn_s) begin
                        state  <= HELD;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state     <= IDLE;
                        db_cnt    <= '0;
                        btn_level <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + DB_ONE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    db_cnt    <= '0;
                    btn_level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_step_debouncer.sv
// Scoreboard bench: a run-length reference model predicts step/btn_level per edge.
module tb_btn_step_debouncer;

    localparam int D  = 4;
    localparam int RD = 8;
    localparam int RP = 4;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    logic step;
    logic btn_level;

    always #5 clk = ~clk;

    btn_step_debouncer #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .step      (step),
        .btn_level (btn_level)
    );

    typedef struct {
        int   edge_n;
        logic exp_step;
        logic exp_level;
    } exp_t;

    exp_t sb[$];

    int cyc            = 0;
    int compared       = 0;
    int mismatched     = 0;
    int n_steps        = 0;
    int last_step_edge = 0;

    // Reference model state: edge index, delayed samples, debounced level,
    // length of the current run of samples disagreeing with the level, and
    // the edge at which the button was last (re)confirmed as held.
    int   k       = 0;
    logic m_s1    = 1'b0;
    logic m_s2    = 1'b0;
    logic m_lvl   = 1'b0;
    int   m_run   = 0;
    int   m_entry = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s at edge %0d: got %0d, wanted %0d", name, cyc, act, req);
        end
    endtask

    task automatic model_edge(input logic r, input logic b);
        logic samp;
        logic es;
        es = 1'b0;
        k++;
        if (r) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_lvl = 1'b0; m_run = 0; m_entry = k;
        end else begin
            samp = m_s2;
            m_s2 = m_s1;
            m_s1 = b;
            if (samp != m_lvl) begin
                m_run++;
            end else begin
                if (m_lvl && m_run > 0) m_entry = k;
                m_run = 0;
            end
            if (m_run == D) begin
                m_lvl = samp;
                m_run = 0;
                if (samp) begin
                    es = 1'b1;
                    m_entry = k;
                end
            end
`ifdef AUTO_REPEAT_EN
            else if (m_lvl && m_run == 0 && (k - m_entry) >= RD && ((k - m_entry - RD) % RP) == 0)
                es = 1'b1;
`endif
        end
        sb.push_back('{k, es, m_lvl});
    endtask

    task automatic drive(input logic r, input logic b);
        rst    = r;
        btn_in = b;
        model_edge(r, b);
        @(posedge clk);
        #1;
    endtask

    task automatic drive_n(input int n, input logic r, input logic b);
        for (int i = 0; i < n; i++) drive(r, b);
    endtask

    // Monitor: one scoreboard entry per clock edge, compared away from the edge.
    initial begin
        exp_t e;
        logic prev_step;
        prev_step = 1'b0;
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 0, 1);
                end else begin
                    e = sb.pop_front();
                    check("sb_edge", cyc, e.edge_n);
                    check("step", int'(step), int'(e.exp_step));
                    check("btn_level", int'(btn_level), int'(e.exp_level));
                end
                if (step && prev_step) check("step_back_to_back", 1, 0);
                if (step) begin
                    n_steps++;
                    last_step_edge = cyc;
                end
                prev_step = step;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k0;
        int s0;
        rst    = 1'b1;
        btn_in = 1'b0;

        // Reset with a toggling button.
        for (int i = 0; i < 3; i++) drive(1'b1, (i % 2) == 1);

        // Clean press: step at edge 6 relative to the first high sample.
        k0 = k; s0 = n_steps;
        drive_n(20, 1'b0, 1'b1);
        drive_n(8, 1'b0, 1'b0);
`ifndef AUTO_REPEAT_EN
        check("press_step_count", n_steps - s0, 1);
        check("press_step_edge", last_step_edge - k0, 6);
`endif

        // Bounce that never settles, then a settled press.
        drive_n(2, 1'b1, 1'b0);
        s0 = n_steps;
        for (int r = 0; r < 8; r++) begin
            drive_n(3, 1'b0, 1'b1);
            drive(1'b0, 1'b0);
        end
        drive_n(3, 1'b0, 1'b0);
        check("bounce_no_step", n_steps - s0, 0);
        drive_n(6, 1'b0, 1'b1);
        drive_n(8, 1'b0, 1'b0);
        check("settled_one_step", n_steps - s0, 1);

        // Short dropout while held, then a real release.
        drive_n(2, 1'b1, 1'b0);
        s0 = n_steps;
        drive_n(10, 1'b0, 1'b1);
        drive_n(2, 1'b0, 1'b0);
        drive_n(6, 1'b0, 1'b1);
        drive_n(8, 1'b0, 1'b0);
        check("dropout_one_step", n_steps - s0, 1);

        // Reset in the middle of a press debounce while the button stays down.
        drive_n(2, 1'b1, 1'b0);
        s0 = n_steps;
        drive_n(4, 1'b0, 1'b1);
        drive_n(2, 1'b1, 1'b1);
        k0 = k;
        drive_n(10, 1'b0, 1'b1);
        drive_n(8, 1'b0, 1'b0);
        check("rst_abort_step_count", n_steps - s0, 1);
        check("rst_abort_step_edge", last_step_edge - k0, 6);

`ifdef AUTO_REPEAT_EN
        // Long hold with auto-repeat: edges 6, 14, 18, 22, 26, 30.
        drive_n(2, 1'b1, 1'b0);
        k0 = k; s0 = n_steps;
        drive_n(30, 1'b0, 1'b1);
        drive_n(8, 1'b0, 1'b0);
        check("repeat_step_count", n_steps - s0, 6);
        check("repeat_last_edge", last_step_edge - k0, 30);
`endif

        // Random bouncy segments with occasional resets.
        for (int seg = 0; seg < 400; seg++) begin
            logic lvl;
            int   len;
            lvl = ($urandom_range(0, 1) == 1);
            len = ($urandom_range(0, 5) == 0) ? $urandom_range(8, 24) : $urandom_range(1, 6);
            if ($urandom_range(0, 39) == 0)
                drive_n($urandom_range(1, 3), 1'b1, lvl);
            else
                drive_n(len, 1'b0, lvl);
        end
        drive_n(10, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
